// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer and its helpers.
// Contents: control-word width and field positions, FSM state encodings,
// PC function codes, the fixed fetch control word and the memory-stall
// gating function applied to execute-state control words.
package cpu_ctrl_pkg;

  localparam int CW_W = 33;

  // Control-word field positions
  localparam int CW_REG_W       = 9;
  localparam int CW_RAM_EN      = 8;
  localparam int CW_PC_FS_HI    = 5;
  localparam int CW_PC_FS_LO    = 4;
  localparam int CW_STATUS_LOAD = 2;
  localparam int CW_NS_HI       = 1;
  localparam int CW_NS_LO       = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EX1   = 2'b01,
    ST_EX2   = 2'b10,
    ST_EX3   = 2'b11
  } state_t;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;

  // Fetch drives RAM data onto the bus and nothing else
  localparam logic [CW_W-1:0] FETCH_CW = 33'h0_0000_0100;

  // While RAM is not ready the datapath must not commit anything:
  // suppress register write, flag load and PC update, keep the rest.
  function automatic logic [CW_W-1:0] cw_stall_gate(input logic [CW_W-1:0] cw);
    logic [CW_W-1:0] g;
    g                            = cw;
    g[CW_REG_W]                  = 1'b0;
    g[CW_STATUS_LOAD]            = 1'b0;
    g[CW_PC_FS_HI:CW_PC_FS_LO]   = PC_HOLD;
    return g;
  endfunction

endpackage

// File: rtl/control_sequencer_cw_select.sv
// cw_select: picks the control word of the lowest-index decoder whose
// opcode match bit is set.
// Ports:
//   i_dec_hit  per-decoder match bits
//   i_dec_cw   flattened control words, decoder i at [CW_W*i +: CW_W]
//   o_cw       selected control word (decoder 0's word when nothing hits)
//   o_hit_any  at least one decoder matched
module cw_select
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_DEC = 4
) (
  input  logic [NUM_DEC-1:0]      i_dec_hit,
  input  logic [NUM_DEC*CW_W-1:0] i_dec_cw,
  output logic [CW_W-1:0]         o_cw,
  output logic                    o_hit_any
);

  localparam int SEL_W = (NUM_DEC > 1) ? $clog2(NUM_DEC) : 1;

  logic [SEL_W-1:0] w_sel;
  logic [CW_W-1:0]  w_cw;

  // Priority encode: scanning downward leaves the lowest set index last
  always_comb begin
    w_sel = '0;
    for (int i = NUM_DEC - 1; i >= 0; i--) begin
      w_sel = i_dec_hit[i] ? SEL_W'(i) : w_sel;
    end
  end

  // NUM_DEC:1 mux of the decoder control words
  always_comb begin
    w_cw = '0;
    for (int i = 0; i < NUM_DEC; i++) begin
      w_cw = (w_sel == SEL_W'(i)) ? i_dec_cw[i*CW_W +: CW_W] : w_cw;
    end
  end

  assign o_cw      = w_cw;
  assign o_hit_any = |i_dec_hit;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control FSM for the CPU datapath.
// Fetches an instruction into the IR, then forwards the control word of the
// matching class decoder each execute state until a word with NS=00 retires
// the instruction. Handles memory-stall gating, status latching, sticky
// illegal-opcode trap and a retired-instruction counter.
// Ports:
//   i_clock, i_reset_n   clock, synchronous active-low reset
//   i_run                permission to start a new fetch
//   i_mem_ready          RAM access completes this cycle
//   i_instr_in           RAM read data during fetch
//   i_status_in          ALU flags from the datapath
//   i_dec_hit, i_dec_cw  per-decoder match bits and flattened control words
//   o_ir, o_state        instruction register and FSM state (to decoders)
//   o_status             latched flags (to branch decoder)
//   o_cw_out             control word to datapath
//   o_illegal_op         sticky trap indicator
//   o_retired            completed-instruction count
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_DEC = 4,
  parameter int CNT_W   = 32
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_run,
  input  logic                    i_mem_ready,
  input  logic [31:0]             i_instr_in,
  input  logic [4:0]              i_status_in,
  input  logic [NUM_DEC-1:0]      i_dec_hit,
  input  logic [NUM_DEC*CW_W-1:0] i_dec_cw,
  output logic [31:0]             o_ir,
  output logic [1:0]              o_state,
  output logic [4:0]              o_status,
  output logic [CW_W-1:0]         o_cw_out,
  output logic                    o_illegal_op,
  output logic [CNT_W-1:0]        o_retired
);

  state_t           r_state;
  logic             r_trap;
  logic [31:0]      r_ir;
  logic [4:0]       r_status;
  logic [CNT_W-1:0] r_retired;

  logic [CW_W-1:0]  w_sel_cw;
  logic             w_hit_any;
  logic             w_fetch_go;
  logic             w_stall;
  state_t           w_state_nxt;
  logic             w_trap_nxt;
  logic             w_retire;
  logic             w_ir_load;
  logic [CW_W-1:0]  w_cw;

  cw_select #(
    .NUM_DEC (NUM_DEC)
  ) u_cw_select (
    .i_dec_hit (i_dec_hit),
    .i_dec_cw  (i_dec_cw),
    .o_cw      (w_sel_cw),
    .o_hit_any (w_hit_any)
  );

  assign w_fetch_go = i_run & i_mem_ready;
  assign w_stall    = w_sel_cw[CW_RAM_EN] & ~i_mem_ready;

  // State register and trap flag
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= ST_FETCH;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_trap  <= w_trap_nxt;
    end
  end

  // Next-state logic; also flags IR load and instruction retirement
  always_comb begin
    w_state_nxt = r_state;
    w_trap_nxt  = r_trap;
    w_retire    = 1'b0;
    w_ir_load   = 1'b0;
    if (r_trap) begin
      w_state_nxt = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_fetch_go) begin
            w_state_nxt = ST_EX1;
            w_ir_load   = 1'b1;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_EX1, ST_EX2, ST_EX3: begin
          if (!w_hit_any) begin
            // Trap parks the visible state at FETCH
            w_trap_nxt  = 1'b1;
            w_state_nxt = ST_FETCH;
          end else if (w_stall) begin
            w_state_nxt = r_state;
          end else begin
            w_state_nxt = state_t'(w_sel_cw[CW_NS_HI:CW_NS_LO]);
            w_retire    = (w_sel_cw[CW_NS_HI:CW_NS_LO] == ST_FETCH);
          end
        end
        default: begin
          w_state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  // Output control word; zero while in reset or trapped
  always_comb begin
    w_cw = '0;
    if (!i_reset_n) begin
      w_cw = '0;
    end else if (r_trap) begin
      w_cw = '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          w_cw                          = FETCH_CW;
          w_cw[CW_PC_FS_HI:CW_PC_FS_LO] = w_fetch_go ? PC_INC : PC_HOLD;
        end
        ST_EX1, ST_EX2, ST_EX3: begin
          if (!w_hit_any) begin
            w_cw = '0;
          end else if (w_stall) begin
            w_cw = cw_stall_gate(w_sel_cw);
          end else begin
            w_cw = w_sel_cw;
          end
        end
        default: begin
          w_cw = '0;
        end
      endcase
    end
  end

  // IR, latched status and retired counter
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_ir      <= 32'h0000_0000;
      r_status  <= 5'b00000;
      r_retired <= '0;
    end else begin
      if (w_ir_load) begin
        r_ir <= i_instr_in;
      end else begin
        r_ir <= r_ir;
      end
      if (w_cw[CW_STATUS_LOAD]) begin
        r_status <= i_status_in;
      end else begin
        r_status <= r_status;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  assign o_ir         = r_ir;
  assign o_state      = r_state;
  assign o_status     = r_status;
  assign o_cw_out     = w_cw;
  assign o_illegal_op = r_trap;
  assign o_retired    = r_retired;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. Each instruction expected to
// retire has its IR value queued when it is fetched; a monitor pops the queue
// whenever the retired counter moves and checks IR and count.
module tb_control_sequencer;

  localparam int NUM_DEC = 4;
  localparam int CNT_W   = 32;

  localparam logic [32:0] C_FETCH     = 33'h0_0000_0100;
  localparam logic [32:0] C_FETCH_INC = 33'h0_0000_0110;
  localparam logic [32:0] CW_A        = 33'h1_0000_0E00;
  localparam logic [32:0] CW_LD       = 33'h0_0002_8310;
  localparam logic [32:0] CW_LD_G     = 33'h0_0002_8100;
  localparam logic [32:0] CW_M1       = 33'h1_0000_0002;
  localparam logic [32:0] CW_M2       = 33'h0_0000_0007;
  localparam logic [32:0] CW_M3       = 33'h0_0000_0200;
  localparam logic [32:0] CW_P1       = 33'h0_8000_0000;
  localparam logic [32:0] CW_P2       = 33'h0_4000_0000;

  logic              clk;
  logic              reset_n;
  logic              run;
  logic              mem_ready;
  logic [31:0]       instr_in;
  logic [4:0]        status_in;
  logic [3:0]        dec_hit;
  logic [32:0]       cw_tab [4];
  logic [4*33-1:0]   dec_cw;
  logic [31:0]       o_ir;
  logic [1:0]        o_state;
  logic [4:0]        o_status;
  logic [32:0]       o_cw_out;
  logic              o_illegal_op;
  logic [CNT_W-1:0]  o_retired;

  int                chk_cnt;
  int                pass_cnt;
  logic [31:0]       exp_q [$];
  logic [31:0]       sb_exp;
  logic [CNT_W-1:0]  prev_ret;
  logic [CNT_W-1:0]  model_ret;

  assign dec_cw = {cw_tab[3], cw_tab[2], cw_tab[1], cw_tab[0]};

  control_sequencer #(
    .NUM_DEC (NUM_DEC),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (reset_n),
    .i_run        (run),
    .i_mem_ready  (mem_ready),
    .i_instr_in   (instr_in),
    .i_status_in  (status_in),
    .i_dec_hit    (dec_hit),
    .i_dec_cw     (dec_cw),
    .o_ir         (o_ir),
    .o_state      (o_state),
    .o_status     (o_status),
    .o_cw_out     (o_cw_out),
    .o_illegal_op (o_illegal_op),
    .o_retired    (o_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every retirement must match the oldest queued IR
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      exp_q.delete();
      prev_ret = '0;
    end else if (o_retired !== prev_ret) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_retire: retired=%0d but no instruction pending", o_retired);
      end else begin
        sb_exp = exp_q.pop_front();
        if (o_ir !== sb_exp || o_retired !== prev_ret + 32'd1)
          $display("FAIL sb_retire: ir=%h retired=%0d, expected ir=%h retired=%0d",
                   o_ir, o_retired, sb_exp, prev_ret + 32'd1);
        else pass_cnt++;
      end
      prev_ret = o_retired;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; run = 1'b1; mem_ready = 1'b1;
    #1;
    chk_cnt++; if (o_cw_out !== 33'h0) $display("FAIL rst_cw: got %h expected 0", o_cw_out); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (o_state !== 2'b00 || o_ir !== 32'h0 || o_status !== 5'b0 || o_illegal_op !== 1'b0 || o_retired !== 32'd0)
      $display("FAIL rst_regs: state=%b ir=%h status=%b ill=%b ret=%0d expected all zero",
               o_state, o_ir, o_status, o_illegal_op, o_retired);
    else pass_cnt++;
    model_ret = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    reset_n = 1'b1; run = 1'b1; mem_ready = 1'b1; instr_in = 32'h91000441;
    dec_hit = 4'b0001; cw_tab[0] = CW_A;
    exp_q.push_back(32'h91000441);
    #1;
    chk_cnt++; if (o_cw_out !== C_FETCH_INC) $display("FAIL single_fetch_cw: got %h expected %h", o_cw_out, C_FETCH_INC); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (o_ir !== 32'h91000441 || o_state !== 2'b01) $display("FAIL single_load: ir=%h state=%b expected 91000441/01", o_ir, o_state); else pass_cnt++;
    @(negedge clk);
    run = 1'b0;
    #1;
    chk_cnt++; if (o_cw_out !== CW_A) $display("FAIL single_ex_cw: got %h expected %h", o_cw_out, CW_A); else pass_cnt++;
    @(posedge clk); #1;
    model_ret++;
    chk_cnt++; if (o_state !== 2'b00 || o_retired !== model_ret) $display("FAIL single_done: state=%b ret=%0d expected 00/%0d", o_state, o_retired, model_ret); else pass_cnt++;
  endtask

  task automatic test_run_low();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run = 1'b0; mem_ready = 1'b1; instr_in = 32'hDEADBEEF;
      #1;
      chk_cnt++; if (o_cw_out !== C_FETCH) $display("FAIL runlow_cw: got %h expected %h", o_cw_out, C_FETCH); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (o_state !== 2'b00 || o_ir !== 32'h91000441) $display("FAIL runlow_hold: state=%b ir=%h expected 00/91000441", o_state, o_ir); else pass_cnt++;
    end
  endtask

  task automatic test_fetch_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      run = 1'b1; mem_ready = 1'b0; instr_in = 32'h12345678;
      #1;
      chk_cnt++; if (o_cw_out !== C_FETCH) $display("FAIL fwait_cw: got %h expected %h", o_cw_out, C_FETCH); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (o_state !== 2'b00 || o_ir !== 32'h91000441) $display("FAIL fwait_hold: state=%b ir=%h expected 00/91000441", o_state, o_ir); else pass_cnt++;
    end
    @(negedge clk);
    mem_ready = 1'b1;
    exp_q.push_back(32'h12345678);
    #1;
    chk_cnt++; if (o_cw_out !== C_FETCH_INC) $display("FAIL fwait_inc: got %h expected %h", o_cw_out, C_FETCH_INC); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (o_ir !== 32'h12345678 || o_state !== 2'b01) $display("FAIL fwait_load: ir=%h state=%b expected 12345678/01", o_ir, o_state); else pass_cnt++;
    @(negedge clk);
    run = 1'b0;
    @(posedge clk); #1;
    model_ret++;
    chk_cnt++; if (o_state !== 2'b00) $display("FAIL fwait_done: state=%b expected 00", o_state); else pass_cnt++;
  endtask

  task automatic test_mem_stall();
    @(negedge clk);
    run = 1'b1; mem_ready = 1'b1; instr_in = 32'h8C220010; cw_tab[0] = CW_LD;
    exp_q.push_back(32'h8C220010);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      run = 1'b0; mem_ready = 1'b0;
      #1;
      chk_cnt++; if (o_cw_out !== CW_LD_G) $display("FAIL stall_cw: got %h expected %h", o_cw_out, CW_LD_G); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (o_state !== 2'b01) $display("FAIL stall_hold: state=%b expected 01", o_state); else pass_cnt++;
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk_cnt++; if (o_cw_out !== CW_LD) $display("FAIL stall_release_cw: got %h expected %h", o_cw_out, CW_LD); else pass_cnt++;
    @(posedge clk); #1;
    model_ret++;
    chk_cnt++; if (o_state !== 2'b00 || o_retired !== model_ret) $display("FAIL stall_done: state=%b ret=%0d expected 00/%0d", o_state, o_retired, model_ret); else pass_cnt++;
  endtask

  task automatic test_multi_state();
    @(negedge clk);
    run = 1'b1; mem_ready = 1'b1; instr_in = 32'h10000003; status_in = 5'b10101;
    dec_hit = 4'b0100; cw_tab[2] = CW_M1;
    exp_q.push_back(32'h10000003);
    @(posedge clk); #1;
    @(negedge clk);
    run = 1'b0;
    #1;
    chk_cnt++; if (o_cw_out !== CW_M1) $display("FAIL multi_ex1_cw: got %h expected %h", o_cw_out, CW_M1); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (o_state !== 2'b10 || o_status !== 5'b00000) $display("FAIL multi_ex1: state=%b status=%b expected 10/00000", o_state, o_status); else pass_cnt++;
    @(negedge clk);
    cw_tab[2] = CW_M2;
    @(posedge clk); #1;
    chk_cnt++; if (o_state !== 2'b11 || o_status !== 5'b10101 || o_retired !== model_ret)
      $display("FAIL multi_ex2: state=%b status=%b ret=%0d expected 11/10101/%0d", o_state, o_status, o_retired, model_ret); else pass_cnt++;
    @(negedge clk);
    cw_tab[2] = CW_M3; status_in = 5'b01010;
    @(posedge clk); #1;
    model_ret++;
    chk_cnt++; if (o_state !== 2'b00 || o_retired !== model_ret || o_status !== 5'b10101)
      $display("FAIL multi_ex3: state=%b ret=%0d status=%b expected 00/%0d/10101", o_state, o_retired, o_status, model_ret); else pass_cnt++;
  endtask

  task automatic test_priority();
    @(negedge clk);
    run = 1'b1; mem_ready = 1'b1; instr_in = 32'h20000001;
    dec_hit = 4'b0110; cw_tab[1] = CW_P1; cw_tab[2] = CW_P2;
    exp_q.push_back(32'h20000001);
    @(posedge clk); #1;
    @(negedge clk);
    run = 1'b0;
    #1;
    chk_cnt++; if (o_cw_out !== CW_P1) $display("FAIL prio_sel: got %h expected %h", o_cw_out, CW_P1); else pass_cnt++;
    @(posedge clk); #1;
    model_ret++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    for (int k = 0; k < 3; k++) begin
      ins = 32'hA0000000 + 32'(k);
      @(negedge clk);
      run = 1'b1; mem_ready = 1'b1; instr_in = ins; dec_hit = 4'b0001; cw_tab[0] = CW_A;
      exp_q.push_back(ins);
      #1;
      chk_cnt++; if (o_cw_out !== C_FETCH_INC) $display("FAIL b2b_fetch: got %h expected %h", o_cw_out, C_FETCH_INC); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (o_state !== 2'b01 || o_ir !== ins) $display("FAIL b2b_load: state=%b ir=%h expected 01/%h", o_state, o_ir, ins); else pass_cnt++;
      @(negedge clk);
      #1;
      chk_cnt++; if (o_cw_out !== CW_A) $display("FAIL b2b_ex: got %h expected %h", o_cw_out, CW_A); else pass_cnt++;
      @(posedge clk); #1;
      model_ret++;
      chk_cnt++; if (o_state !== 2'b00) $display("FAIL b2b_done: state=%b expected 00", o_state); else pass_cnt++;
    end
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    run = 1'b1; mem_ready = 1'b1; instr_in = 32'hFFFF0000; dec_hit = 4'b0001;
    @(posedge clk); #1;
    @(negedge clk);
    dec_hit = 4'b0000;
    @(posedge clk); #1;
    chk_cnt++; if (o_illegal_op !== 1'b1 || o_state !== 2'b00) $display("FAIL ill_enter: ill=%b state=%b expected 1/00", o_illegal_op, o_state); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 1'b1; mem_ready = 1'b1; dec_hit = 4'b0001; instr_in = 32'h11111111;
      #1;
      chk_cnt++; if (o_cw_out !== 33'h0) $display("FAIL ill_cw: got %h expected 0", o_cw_out); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (o_state !== 2'b00 || o_ir !== 32'hFFFF0000 || o_retired !== model_ret || o_illegal_op !== 1'b1)
        $display("FAIL ill_frozen: state=%b ir=%h ret=%0d ill=%b expected 00/ffff0000/%0d/1",
                 o_state, o_ir, o_retired, o_illegal_op, model_ret); else pass_cnt++;
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL sb_drain: %0d pending expected 0", exp_q.size()); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    model_ret = '0;
    chk_cnt++; if (o_illegal_op !== 1'b0 || o_retired !== 32'd0 || o_ir !== 32'h0 || o_status !== 5'b0 || o_state !== 2'b00)
      $display("FAIL ill_reset: ill=%b ret=%0d ir=%h status=%b state=%b expected all zero",
               o_illegal_op, o_retired, o_ir, o_status, o_state); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    reset_n = 1'b1; run = 1'b1; mem_ready = 1'b1; instr_in = 32'h8C000004;
    dec_hit = 4'b0001; cw_tab[0] = CW_LD;
    @(posedge clk); #1;
    @(negedge clk);
    run = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if (o_state !== 2'b01) $display("FAIL abort_stall: state=%b expected 01", o_state); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (o_state !== 2'b00 || o_retired !== 32'd0) $display("FAIL abort_reset: state=%b ret=%0d expected 00/0", o_state, o_retired); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (o_retired !== 32'd0) $display("FAIL abort_noretire: ret=%0d expected 0", o_retired); else pass_cnt++;
  endtask

  initial begin
    chk_cnt = 0; pass_cnt = 0; prev_ret = '0; model_ret = '0;
    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; instr_in = 32'h0;
    status_in = 5'b0; dec_hit = 4'b0;
    for (int i = 0; i < 4; i++) cw_tab[i] = 33'h0;
    test_reset();
    test_single();
    test_run_low();
    test_fetch_wait();
    test_mem_stall();
    test_multi_state();
    test_priority();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
